// File: rtl/conv_req_scheduler.sv
// Two-requester front end for a shared 32-tap convolution engine: round-robin
// grant, per-requester weight banks with lazy reload, credit-protected result FIFO.
module conv_req_scheduler #(
    parameter int RES_DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid,
    input  logic         cfg_bank,
    input  logic [127:0] cfg_weight,
    input  logic         a_valid,
    input  logic [127:0] a_ifm,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [127:0] b_ifm,
    output logic         b_ready,
    output logic         eng_in_valid,
    output logic         eng_weight_valid,
    output logic [127:0] eng_ifm,
    output logic [127:0] eng_weight,
    input  logic         eng_out_valid,
    input  logic [12:0]  eng_ofm,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [12:0]  res_data,
    output logic         res_tag
);

    localparam int CW  = $clog2(RES_DEPTH + 1);
    localparam int CSW = CW + 1;
    localparam int PW  = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

    // Handshakes: a transfer happens exactly in a cycle where valid && ready are
    // both high at the rising edge; ready never depends on the same port's valid.
    logic [CW-1:0]  in_flight;
    logic [CW-1:0]  fifo_count;
    logic [CSW-1:0] credit_sum;
    logic           credit_ok;
    logic           prio;
    logic           a_acc;
    logic           b_acc;
    logic           acc;
    logic           acc_bank;
    logic [127:0]   bank [2];
    logic [1:0]     dirty;
    logic           loaded_valid;
    logic           loaded_bank;
    logic           reload;
    logic           tag_q [RES_DEPTH];
    logic [PW-1:0]  tq_wr;
    logic [PW-1:0]  tq_rd;
    logic           tag_head;
    logic [13:0]    fifo_mem [RES_DEPTH];
    logic [PW-1:0]  f_wr;
    logic [PW-1:0]  f_rd;
    logic           push;
    logic           pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign credit_sum = {1'b0, in_flight} + {1'b0, fifo_count};
    assign credit_ok  = credit_sum < CSW'(RES_DEPTH);

    // prio: 0 = A has priority on contention, 1 = B
    assign a_ready  = rst_n && credit_ok && (!b_valid || !prio);
    assign b_ready  = rst_n && credit_ok && (!a_valid || prio);
    assign a_acc    = a_valid && a_ready;
    assign b_acc    = b_valid && b_ready;
    assign acc      = a_acc || b_acc;
    assign acc_bank = b_acc;

    assign reload = acc && (!loaded_valid || (loaded_bank != acc_bank) || dirty[acc_bank]);

    assign push     = eng_out_valid;
    assign pop      = res_valid && res_ready;
    assign tag_head = tag_q[tq_rd];

    assign res_valid           = (fifo_count != '0);
    assign {res_tag, res_data} = fifo_mem[f_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (a_acc) begin
            prio <= 1'b1;
        end else if (b_acc) begin
            prio <= 1'b0;
        end
    end

    // Bank writes set dirty; a reload clears it unless a write lands the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank[0] <= '0;
            bank[1] <= '0;
            dirty   <= '0;
        end else begin
            if (cfg_valid) begin
                bank[cfg_bank] <= cfg_weight;
            end
            for (int k = 0; k < 2; k++) begin
                if (cfg_valid && (cfg_bank == k[0])) begin
                    dirty[k] <= 1'b1;
                end else if (reload && (acc_bank == k[0])) begin
                    dirty[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_in_valid     <= 1'b0;
            eng_weight_valid <= 1'b0;
            eng_ifm          <= '0;
            eng_weight       <= '0;
            loaded_valid     <= 1'b0;
            loaded_bank      <= 1'b0;
        end else begin
            eng_in_valid     <= acc;
            eng_weight_valid <= reload;
            if (acc) begin
                eng_ifm <= acc_bank ? b_ifm : a_ifm;
            end
            if (reload) begin
                eng_weight   <= bank[acc_bank];
                loaded_valid <= 1'b1;
                loaded_bank  <= acc_bank;
            end
        end
    end

    // Owner tags of issued vectors, consumed in order as engine results return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tq_wr <= '0;
            tq_rd <= '0;
            for (int i = 0; i < RES_DEPTH; i++) begin
                tag_q[i] <= 1'b0;
            end
        end else begin
            if (acc) begin
                tag_q[tq_wr] <= acc_bank;
                tq_wr        <= ptr_inc(tq_wr);
            end
            if (eng_out_valid) begin
                tq_rd <= ptr_inc(tq_rd);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_wr <= '0;
            f_rd <= '0;
            for (int i = 0; i < RES_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[f_wr] <= {tag_head, eng_ofm};
                f_wr           <= ptr_inc(f_wr);
            end
            if (pop) begin
                f_rd <= ptr_inc(f_rd);
            end
        end
    end

    // Credits only return on registered counts, so a same-cycle pop frees nothing yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight  <= '0;
            fifo_count <= '0;
        end else begin
            case ({acc, push})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(eng_out_valid && (in_flight == '0)));
    assert property (@(posedge clk) disable iff (!rst_n) !(push && (fifo_count == CW'(RES_DEPTH))));

endmodule

// File: tb/tb_conv_req_scheduler.sv
// Bench for conv_req_scheduler: behavioural 2-cycle engine, directed steps and a
// result scoreboard keyed on {tag, data}.
module tb_conv_req_scheduler;

    localparam int RES_DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_valid;
    logic         cfg_bank;
    logic [127:0] cfg_weight;
    logic         a_valid;
    logic [127:0] a_ifm;
    logic         a_ready;
    logic         b_valid;
    logic [127:0] b_ifm;
    logic         b_ready;
    logic         eng_in_valid;
    logic         eng_weight_valid;
    logic [127:0] eng_ifm;
    logic [127:0] eng_weight;
    logic         eng_out_valid;
    logic [12:0]  eng_ofm;
    logic         res_valid;
    logic         res_ready;
    logic [12:0]  res_data;
    logic         res_tag;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           wv_cnt = 0;
    logic [13:0]  exp_q[$];
    logic [127:0] tb_bank [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_req_scheduler #(.RES_DEPTH(RES_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_bank(cfg_bank), .cfg_weight(cfg_weight),
        .a_valid(a_valid), .a_ifm(a_ifm), .a_ready(a_ready),
        .b_valid(b_valid), .b_ifm(b_ifm), .b_ready(b_ready),
        .eng_in_valid(eng_in_valid), .eng_weight_valid(eng_weight_valid),
        .eng_ifm(eng_ifm), .eng_weight(eng_weight),
        .eng_out_valid(eng_out_valid), .eng_ofm(eng_ofm),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag)
    );

    function automatic logic [12:0] dot(input logic [127:0] x, input logic [127:0] w);
        int s = 0;
        for (int k = 0; k < 32; k++) begin
            s += int'(x[4*k +: 4]) * int'(w[4*k +: 4]);
        end
        return s[12:0];
    endfunction

    function automatic logic [127:0] uniform(input logic [3:0] v);
        return {32{v}};
    endfunction

    // Engine: result two cycles after in_valid, using weights captured up to that cycle.
    logic         e_v1;
    logic [12:0]  e_p1;
    logic [127:0] e_w;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_v1 <= 1'b0; e_p1 <= '0; e_w <= '0;
            eng_out_valid <= 1'b0; eng_ofm <= '0;
        end else begin
            if (eng_weight_valid) e_w <= eng_weight;
            e_v1          <= eng_in_valid;
            e_p1          <= dot(eng_ifm, eng_weight_valid ? eng_weight : e_w);
            eng_out_valid <= e_v1;
            eng_ofm       <= e_p1;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cfg_write(input logic bnk, input logic [127:0] w);
        cfg_valid = 1'b1; cfg_bank = bnk; cfg_weight = w;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        tb_bank[bnk] = w;
    endtask

    task automatic send(input logic port, input logic [127:0] ifm, output int acc_cyc);
        bit done = 0;
        acc_cyc = -1;
        if (port == 1'b0) begin a_valid = 1'b1; a_ifm = ifm; end
        else begin b_valid = 1'b1; b_ifm = ifm; end
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if ((port == 1'b0 && a_ready) || (port == 1'b1 && b_ready)) begin
                done = 1;
                acc_cyc = cyc;
                exp_q.push_back({port, dot(ifm, tb_bank[port])});
            end
            @(posedge clk); #1;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        check("send_accepted", done, 1);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_complete", exp_q.size(), 0);
    endtask

    initial begin
        int t;
        int lat;
        int w0;
        int k;
        int grant;
        int seen;
        logic [127:0] r;

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_bank = 1'b0; cfg_weight = '0;
        a_valid = 1'b1; b_valid = 1'b1; a_ifm = uniform(4'd7); b_ifm = uniform(4'd9);
        res_ready = 1'b1;
        tb_bank[0] = '0; tb_bank[1] = '0;

        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (eng_weight_valid) wv_cnt++;
                    if (res_valid && res_ready) begin
                        checks++;
                        assert (exp_q.size() != 0) else begin
                            errors++;
                            $error("FAIL sb_unexpected observed=%0h expected=none", {res_tag, res_data});
                        end
                        if (exp_q.size() != 0) check("sb_result", {res_tag, res_data}, exp_q.pop_front());
                    end
                end
            end
            begin
                #300000;
                $error("FAIL watchdog observed=timeout expected=finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_eng_in_valid", eng_in_valid, 0);
        check("rst_eng_weight_valid", eng_weight_valid, 0);
        check("rst_eng_ifm", eng_ifm, 0);
        check("rst_eng_weight", eng_weight, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_tag", res_tag, 0);
        a_valid = 1'b0; b_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single A request, latency and one weight load
        cfg_write(1'b0, uniform(4'd1));
        w0 = wv_cnt;
        send(1'b0, uniform(4'd2), t);
        check("t1_expected_64", dot(uniform(4'd2), tb_bank[0]), 64);
        lat = -1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(negedge clk);
            if (res_valid) lat = cyc - t;
        end
        check("t1_latency", lat, 4);
        wait_drain();
        check("t1_weight_pulses", wv_cnt - w0, 1);

        // Maximum result from B
        cfg_write(1'b1, uniform(4'd15));
        send(1'b1, uniform(4'd15), t);
        wait_drain();

        // Contention: alternating grants, reload on every issue
        cfg_write(1'b0, uniform(4'd1));
        cfg_write(1'b1, uniform(4'd2));
        w0 = wv_cnt;
        a_valid = 1'b1; b_valid = 1'b1; a_ifm = uniform(4'd1); b_ifm = uniform(4'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            grant = a_ready ? 0 : (b_ready ? 1 : 2);
            check("t3_grant", grant, i % 2);
            if (grant < 2) exp_q.push_back({grant[0], dot(uniform(4'd1), tb_bank[grant[0]])});
            @(posedge clk); #1;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        wait_drain();
        check("t3_weight_pulses", wv_cnt - w0, 8);

        // Backpressure: credit limit stops A after RES_DEPTH accepts
        res_ready = 1'b0;
        k = 0;
        a_valid = 1'b1; a_ifm = uniform(4'd1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (a_ready) begin
                exp_q.push_back({1'b0, dot(a_ifm, tb_bank[0])});
                k++;
            end
            @(posedge clk); #1;
            a_ifm = uniform(4'(k + 1));
        end
        check("t4_accepts", k, RES_DEPTH);
        @(negedge clk);
        check("t4_a_ready_low", a_ready, 0);
        check("t4_res_valid", res_valid, 1);
        check("t4_head_data", res_data, 32);
        repeat (3) @(negedge clk);
        check("t4_head_stable", {res_tag, res_data}, {1'b0, 13'd32});
        @(posedge clk); #1;
        a_valid = 1'b0;
        res_ready = 1'b1;
        wait_drain();
        send(1'b0, uniform(4'd3), t);
        wait_drain();

        // Config write in the same cycle as an issue from that bank
        w0 = wv_cnt;
        cfg_valid = 1'b1; cfg_bank = 1'b0; cfg_weight = uniform(4'd3);
        a_valid = 1'b1; a_ifm = uniform(4'd1);
        @(negedge clk);
        check("t5_same_cycle_ready", a_ready, 1);
        if (a_ready) exp_q.push_back({1'b0, dot(uniform(4'd1), tb_bank[0])});
        @(posedge clk); #1;
        cfg_valid = 1'b0; a_valid = 1'b0;
        tb_bank[0] = uniform(4'd3);
        wait_drain();
        check("t5_no_reload_old", wv_cnt - w0, 0);
        send(1'b0, uniform(4'd1), t);
        check("t5_expected_96", dot(uniform(4'd1), tb_bank[0]), 96);
        wait_drain();
        check("t5_reload_new", wv_cnt - w0, 1);

        // Random weights and vectors on random ports
        cfg_write(1'b0, {$urandom, $urandom, $urandom, $urandom});
        cfg_write(1'b1, {$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 6; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            send(1'($urandom_range(0, 1)), r, t);
        end
        wait_drain();

        // Reset with three requests in flight
        k = 0;
        a_valid = 1'b1; a_ifm = uniform(4'd1);
        for (int i = 0; i < 20 && k < 3; i++) begin
            @(negedge clk);
            if (a_ready) begin
                exp_q.push_back({1'b0, dot(a_ifm, tb_bank[0])});
                k++;
            end
            @(posedge clk);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_in_flight_count", k, 3);
        check("t6_a_ready", a_ready, 0);
        check("t6_eng_in_valid", eng_in_valid, 0);
        check("t6_eng_weight_valid", eng_weight_valid, 0);
        check("t6_eng_ifm", eng_ifm, 0);
        check("t6_eng_weight", eng_weight, 0);
        check("t6_res_valid", res_valid, 0);
        check("t6_res_data", {res_tag, res_data}, 0);
        exp_q.delete();
        a_valid = 1'b0;
        tb_bank[0] = '0; tb_bank[1] = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        check("t6_fifo_empty", seen, 0);
        @(posedge clk); #1;
        w0 = wv_cnt;
        send(1'b0, uniform(4'd5), t);
        wait_drain();
        check("t6_first_issue_reload", wv_cnt - w0, 1);

        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
